// File: rtl/mlp_neuron_engine_if.sv
// Operand-feed and result handshake bundle between the layer sequencer,
// the neuron engine and the layer output buffer.
interface mlp_neuron_engine_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic [LANES*IN_W-1:0]   in_data;
  logic [LANES*IN_W-1:0]   in_weight;
  logic [IN_W-1:0]         in_bias;
  logic [1:0]              cfg_act;
  logic [4:0]              cfg_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_sat;
  logic [15:0]             out_beats;

  modport master (
    output in_valid, in_last, in_data, in_weight, in_bias, cfg_act, cfg_shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_beats
  );

  modport slave (
    input  in_valid, in_last, in_data, in_weight, in_bias, cfg_act, cfg_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_beats
  );
endinterface

// File: rtl/mlp_neuron_engine.sv
// Saturating dot-product neuron: accumulates LANES products per beat, then
// adds bias, requantises with rounding shift, activates and saturates to OUT_W.
module mlp_neuron_engine #(
  parameter int unsigned LANES     = 8,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned CLAMP_MAX = 96
) (
  input  logic                 clk,
  input  logic                 rst,
  mlp_neuron_engine_if.slave   io
);

  // Two guard bits keep acc + lane sum exact before saturation.
  localparam int unsigned EXT_W = ACC_W + 2;
  localparam int unsigned RQ_W  = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] ACC_MAX_X = (EXT_W'(1) <<< (ACC_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] ACC_MIN_X = -ACC_MAX_X - EXT_W'(1);
  localparam logic signed [RQ_W-1:0]  OUT_MAX_X = (RQ_W'(1) <<< (OUT_W - 1)) - RQ_W'(1);
  localparam logic signed [RQ_W-1:0]  OUT_MIN_X = -OUT_MAX_X - RQ_W'(1);
  localparam logic signed [RQ_W-1:0]  CLAMP_X   = RQ_W'(CLAMP_MAX);

  typedef enum logic [1:0] {S_ACCUM, S_FINISH, S_OUT} state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_sat;
  logic [15:0]              r_beats;
  logic [1:0]               r_act;
  logic [4:0]               r_shift;
  logic signed [IN_W-1:0]   r_bias;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_out_sat;
  logic [15:0]              r_out_beats;

  logic signed [2*IN_W-1:0] w_prod;
  logic signed [EXT_W-1:0]  w_sum;
  logic signed [EXT_W-1:0]  w_acc_x;
  logic signed [ACC_W-1:0]  w_acc_sat;
  logic                     w_acc_ovf;
  logic signed [EXT_W-1:0]  w_b_x;
  logic signed [ACC_W-1:0]  w_b;
  logic                     w_b_ovf;
  logic signed [RQ_W-1:0]   w_half;
  logic signed [RQ_W-1:0]   w_rnd_x;
  logic signed [RQ_W-1:0]   w_r;
  logic signed [RQ_W-1:0]   w_a;
  logic [OUT_W-1:0]         w_out;
  logic                     w_out_ovf;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] x);
    if (x > ACC_MAX_X)      return ACC_MAX_X[ACC_W-1:0];
    else if (x < ACC_MIN_X) return ACC_MIN_X[ACC_W-1:0];
    else                    return x[ACC_W-1:0];
  endfunction

  always_comb begin
    w_prod = '0;
    w_sum  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_prod = $signed(io.in_data[i*IN_W +: IN_W]) * $signed(io.in_weight[i*IN_W +: IN_W]);
      w_sum  = w_sum + EXT_W'(w_prod);
    end
    w_acc_x   = EXT_W'(r_acc) + w_sum;
    w_acc_sat = sat_acc(w_acc_x);
    w_acc_ovf = (EXT_W'(w_acc_sat) != w_acc_x);
  end

  // Finish path: bias, rounding shift (one extra bit so the half-LSB add cannot wrap), activation.
  always_comb begin
    w_b_x   = EXT_W'(r_acc) + EXT_W'(r_bias);
    w_b     = sat_acc(w_b_x);
    w_b_ovf = (EXT_W'(w_b) != w_b_x);
    w_half  = (r_shift == 5'd0) ? '0 : (RQ_W'(1) <<< (r_shift - 5'd1));
    w_rnd_x = RQ_W'(w_b) + w_half;
    w_r     = w_rnd_x >>> r_shift;
    unique case (r_act)
      2'd0:    w_a = w_r;
      2'd1:    w_a = (w_r < 0) ? '0 : w_r;
      2'd2:    w_a = (w_r < 0) ? (w_r >>> 3) : w_r;
      default: w_a = (w_r < 0) ? '0 : ((w_r > CLAMP_X) ? CLAMP_X : w_r);
    endcase
    w_out_ovf = 1'b1;
    if (w_a > OUT_MAX_X)      w_out = OUT_MAX_X[OUT_W-1:0];
    else if (w_a < OUT_MIN_X) w_out = OUT_MIN_X[OUT_W-1:0];
    else begin
      w_out     = w_a[OUT_W-1:0];
      w_out_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_beats     <= '0;
      r_act       <= '0;
      r_shift     <= '0;
      r_bias      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_beats <= '0;
    end else begin
      unique case (r_state)
        S_ACCUM: begin
          if (io.in_valid && r_in_ready) begin
            r_acc <= w_acc_sat;
            if (w_acc_ovf) r_sat <= 1'b1;
            if (r_beats != '1) r_beats <= r_beats + 16'd1;
            if (r_beats == '0) begin
              r_act   <= io.cfg_act;
              r_shift <= io.cfg_shift;
            end
            if (io.in_last) begin
              r_bias     <= io.in_bias;
              r_in_ready <= 1'b0;
              r_state    <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          r_out_data  <= w_out;
          r_out_sat   <= r_sat | w_b_ovf | w_out_ovf;
          r_out_beats <= r_beats;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (io.out_ready) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign io.in_ready  = r_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_data  = r_out_data;
  assign io.out_sat   = r_out_sat;
  assign io.out_beats = r_out_beats;

endmodule

// File: tb/tb_mlp_neuron_engine.sv
// Scoreboard bench for mlp_neuron_engine: a behavioural model queues the
// expected result as each vector is driven; results are popped on out_valid.
module tb_mlp_neuron_engine;
  localparam int LANES = 8;
  localparam int IN_W  = 8;
  localparam int ACC_W = 24;
  localparam int OUT_W = 8;
  localparam int CLAMP = 96;
  localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W - 1));

  typedef struct {
    longint data;
    longint sat;
    longint beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mlp_neuron_engine_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) io ();

  mlp_neuron_engine #(
    .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CLAMP_MAX(CLAMP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_beat(input logic [LANES*IN_W-1:0] d, input logic [LANES*IN_W-1:0] w,
                            input logic last, input int bias, input int act, input int shift);
    int guard;
    logic [31:0] bv;
    bv = bias;
    guard = 0;
    io.in_valid  = 1'b1;
    io.in_last   = last;
    io.in_data   = d;
    io.in_weight = w;
    io.in_bias   = bv[IN_W-1:0];
    io.cfg_act   = 2'(act);
    io.cfg_shift = 5'(shift);
    while (!io.in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) check_val("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
  endtask

  // Lanes get dv/wv, or random values when rnd is set; cfg/bias are junk on non-qualifying beats.
  task automatic send_vec(input int nbeats, input int dv, input int wv, input bit rnd,
                          input int bias, input int act, input int shift);
    longint acc, sum, b, r, a;
    bit sat;
    exp_t e;
    logic [LANES*IN_W-1:0] d, w;
    int dl, wl;
    logic [31:0] t;
    acc = 0;
    sat = 0;
    for (int k = 0; k < nbeats; k++) begin
      sum = 0;
      for (int l = 0; l < LANES; l++) begin
        dl = rnd ? int'($urandom_range(0, 255)) - 128 : dv;
        wl = rnd ? int'($urandom_range(0, 255)) - 128 : wv;
        t = dl; d[l*IN_W +: IN_W] = t[IN_W-1:0];
        t = wl; w[l*IN_W +: IN_W] = t[IN_W-1:0];
        sum += longint'(dl) * longint'(wl);
      end
      acc = acc + sum;
      if (acc > AMAX) begin acc = AMAX; sat = 1; end
      if (acc < AMIN) begin acc = AMIN; sat = 1; end
      drive_beat(d, w, k == nbeats - 1,
                 (k == nbeats - 1) ? bias : int'($urandom_range(0, 255)),
                 (k == 0) ? act : int'($urandom_range(0, 3)),
                 (k == 0) ? shift : int'($urandom_range(0, 23)));
    end
    b = acc + bias;
    if (b > AMAX) begin b = AMAX; sat = 1; end
    if (b < AMIN) begin b = AMIN; sat = 1; end
    r = (shift == 0) ? b : ((b + (longint'(1) << (shift - 1))) >>> shift);
    case (act)
      0: a = r;
      1: a = (r < 0) ? 0 : r;
      2: a = (r < 0) ? (r >>> 3) : r;
      default: a = (r < 0) ? 0 : ((r > CLAMP) ? CLAMP : r);
    endcase
    if (a > 127) begin a = 127; sat = 1; end
    if (a < -128) begin a = -128; sat = 1; end
    e.data = a;
    e.sat = sat;
    e.beats = (nbeats > 65535) ? 65535 : nbeats;
    sb.push_back(e);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int waited;
    waited = 0;
    while (!io.out_valid && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    check_val("latency", waited, 1);
    if (sb.size() == 0) begin
      check_val("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check_val("out_data", $signed(io.out_data), e.data);
    check_val("out_sat", io.out_sat, e.sat);
    check_val("out_beats", io.out_beats, e.beats);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val("hold_valid", io.out_valid, 1);
      check_val("hold_data", $signed(io.out_data), e.data);
      check_val("hold_beats", io.out_beats, e.beats);
      check_val("hold_in_ready", io.in_ready, 0);
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    check_val("post_valid", io.out_valid, 0);
    check_val("post_in_ready", io.in_ready, 1);
    check_val("post_data_held", $signed(io.out_data), e.data);
  endtask

  initial begin
    logic [LANES*IN_W-1:0] ones;
    io.in_valid  = 1'b0;
    io.in_last   = 1'b0;
    io.in_data   = '0;
    io.in_weight = '0;
    io.in_bias   = '0;
    io.cfg_act   = '0;
    io.cfg_shift = '0;
    io.out_ready = 1'b0;
    for (int l = 0; l < LANES; l++) ones[l*IN_W +: IN_W] = IN_W'(1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_in_ready", io.in_ready, 1);
    check_val("rst_out_valid", io.out_valid, 0);
    check_val("rst_out_data", io.out_data, 0);
    check_val("rst_out_sat", io.out_sat, 0);
    check_val("rst_out_beats", io.out_beats, 0);

    send_vec(1, 2, 3, 0, 4, 1, 0);       collect(0);   // 52
    send_vec(1, -10, 10, 0, 0, 0, 2);    collect(0);   // -128 sat
    send_vec(1, -10, 10, 0, 0, 2, 2);    collect(0);   // -25
    send_vec(1, -10, 10, 0, 0, 1, 2);    collect(0);   // 0
    send_vec(1, 0, 0, 0, 6, 0, 2);       collect(0);   // 2
    send_vec(1, 0, 0, 0, 5, 0, 2);       collect(0);   // 1
    send_vec(1, 0, 0, 0, -6, 0, 2);      collect(0);   // -1
    send_vec(70, 127, 127, 0, 0, 1, 0);  collect(0);   // 127 sat
    send_vec(70, 127, 127, 0, 0, 3, 0);  collect(0);   // 96 sat
    send_vec(3, -128, 127, 0, -20, 2, 4); collect(0);
    send_vec(1, 1, 1, 0, 0, 0, 0);       collect(5);   // 8 after stall
    send_vec(1, 1, 1, 0, 0, 0, 0);       collect(0);
    for (int v = 0; v < 8; v++) begin
      send_vec(int'($urandom_range(1, 4)), 0, 0, 1, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
      collect(int'($urandom_range(0, 2)));
    end

    for (int k = 0; k < 3; k++) drive_beat(ones, ones, 1'b0, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    check_val("arst_out_valid", io.out_valid, 0);
    check_val("arst_in_ready", io.in_ready, 1);
    check_val("arst_out_beats", io.out_beats, 0);
    check_val("arst_out_data", io.out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send_vec(1, 1, 1, 0, 0, 0, 0);       collect(0);   // 8, beats=1

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
